// File: rtl/frame_pkg.sv
// Shared types and constants for the snake-game frame tracker.
package frame_pkg;

  localparam int GRID_W = 16;
  localparam int GRID_H = 12;

  typedef logic [2:0] obj_code_t;

  localparam obj_code_t OBJ_EMPTY  = 3'b000;
  localparam obj_code_t OBJ_HEAD   = 3'b001;
  localparam obj_code_t OBJ_BODY   = 3'b010;
  localparam obj_code_t OBJ_APPLE  = 3'b011;
  localparam obj_code_t OBJ_BORDER = 3'b100;

  // Priority encoder: head > body > apple > border > empty.
  function automatic obj_code_t encode_obj(input logic head, input logic body,
                                           input logic apple, input logic border);
    obj_code_t code;
    if (head) begin
      code = OBJ_HEAD;
    end else if (body) begin
      code = OBJ_BODY;
    end else if (apple) begin
      code = OBJ_APPLE;
    end else if (border) begin
      code = OBJ_BORDER;
    end else begin
      code = OBJ_EMPTY;
    end
    return code;
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Raster-order x/y cell counter: x runs fastest, both wrap at the frame end.
module scan_counter
  import frame_pkg::*;
#(
  parameter int W = GRID_W,
  parameter int H = GRID_H
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [3:0] x,
  output logic [3:0] y
);

  localparam logic [3:0] X_MAX = 4'(W - 1);
  localparam logic [3:0] Y_MAX = 4'(H - 1);

  // Advance one cell per enabled clock; row wrap bumps y, frame wrap returns to (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= 4'd0;
      y <= 4'd0;
    end else if (enable) begin
      if (x == X_MAX) begin
        x <= 4'd0;
        if (y == Y_MAX) begin
          y <= 4'd0;
        end else begin
          y <= y + 4'd1;
        end
      end else begin
        x <= x + 4'd1;
      end
    end
  end

endmodule

// File: rtl/frame_tracker.sv
// Scans the game grid, classifies the object at the current cell and flags
// cells whose code changed since the previous frame.
module frame_tracker
  import frame_pkg::*;
#(
  parameter int GRID_W = frame_pkg::GRID_W,
  parameter int GRID_H = frame_pkg::GRID_H
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       enable,
  input  logic       head,
  input  logic       body,
  input  logic       apple,
  input  logic       border,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [2:0] obj_code,
  output logic       diff
);

  localparam int DEPTH = GRID_W * GRID_H;

  obj_code_t  store [DEPTH];
  logic [7:0] addr;

  scan_counter #(
    .W (GRID_W),
    .H (GRID_H)
  ) u_scan (
    .clk    (clk),
    .rst    (nrst),
    .enable (enable),
    .x      (x),
    .y      (y)
  );

  // Row-major store index of the cell currently being presented.
  always_comb begin
    addr = 8'(32'(y) * GRID_W + 32'(x));
  end

  // Zero-latency classification and change detection against last frame.
  always_comb begin
    obj_code = OBJ_EMPTY;
    diff     = 1'b0;
    obj_code = encode_obj(head, body, apple, border);
    diff     = (obj_code != store[addr]);
  end

  // Frame store: cleared on reset, records the current code while the scan advances.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        store[i] <= OBJ_EMPTY;
      end
    end else if (enable) begin
      store[addr] <= obj_code;
    end
  end

endmodule

// File: tb/tb_frame_tracker.sv
// Self-checking bench for frame_tracker with a cell-index reference model.
module tb_frame_tracker;

  logic       clk;
  logic       nrst;
  logic       enable;
  logic       head, body, apple, border;
  logic [3:0] x, y;
  logic [2:0] obj_code;
  logic       diff;

  int checks;
  int failures;

  // reference model: linear cell index plus last-written code per cell
  int         pos;
  logic [2:0] mstore [192];
  int         dcount;

  frame_tracker dut (
    .clk      (clk),
    .nrst     (nrst),
    .enable   (enable),
    .head     (head),
    .body     (body),
    .apple    (apple),
    .border   (border),
    .x        (x),
    .y        (y),
    .obj_code (obj_code),
    .diff     (diff)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] ref_code(input logic [3:0] v);
    // v = {head, body, apple, border}
    if (v[3]) return 3'd1;
    if (v[2]) return 3'd2;
    if (v[1]) return 3'd3;
    if (v[0]) return 3'd4;
    return 3'd0;
  endfunction

  // phase 0: head(4,4) apple(6,4); phase 1: head(5,4) body(4,4) apple(7,4)
  function automatic logic [3:0] map_cell(input int phase, input int cx, input int cy);
    logic [3:0] v;
    v = 4'b0000;
    if (cx == 0 || cx == 15 || cy == 0 || cy == 11) v[0] = 1'b1;
    if (phase == 0) begin
      if (cx == 4 && cy == 4) v[3] = 1'b1;
      if (cx == 6 && cy == 4) v[1] = 1'b1;
    end else begin
      if (cx == 5 && cy == 4) v[3] = 1'b1;
      if (cx == 4 && cy == 4) v[2] = 1'b1;
      if (cx == 7 && cy == 4) v[1] = 1'b1;
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] cur_in();
    return {head, body, apple, border};
  endfunction

  task automatic set_in(input logic [3:0] v);
    {head, body, apple, border} = v;
    #1;
  endtask

  task automatic model_reset();
    pos = 0;
    for (int i = 0; i < 192; i++) mstore[i] = 3'd0;
  endtask

  task automatic check_all(input string tag);
    logic [2:0] e;
    e = ref_code(cur_in());
    chk({tag, ".x"}, 8'(x), 8'(pos % 16));
    chk({tag, ".y"}, 8'(y), 8'(pos / 16));
    chk({tag, ".obj"}, 8'(obj_code), 8'(e));
    chk({tag, ".diff"}, 8'(diff), 8'(e != mstore[pos]));
  endtask

  task automatic tick();
    if (enable && !nrst) begin
      mstore[pos] = ref_code(cur_in());
      pos = (pos + 1) % 192;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic map_frame(input int phase, input string tag);
    dcount = 0;
    for (int i = 0; i < 192; i++) begin
      set_in(map_cell(phase, pos % 16, pos / 16));
      check_all(tag);
      if (diff) dcount++;
      tick();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    nrst = 1'b1;
    enable = 1'b0;
    {head, body, apple, border} = 4'b0000;
    model_reset();

    // reset held two cycles then released
    tick();
    tick();
    check_all("reset_hold");
    nrst = 1'b0;
    #1;
    check_all("reset_release");

    // 100 enabled cycles with empty inputs
    enable = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk("after100.obj", 8'(obj_code), 8'd0);
    chk("after100.diff", 8'(diff), 8'd0);
    chk("after100.x", 8'(x), 8'd4);
    chk("after100.y", 8'(y), 8'd6);

    // restart at (0,0) with a clean store
    nrst = 1'b1;
    #1;
    model_reset();
    chk("rst2.x", 8'(x), 8'd0);
    tick();
    nrst = 1'b0;
    #1;

    // first map frame: diff at all non-empty cells (52 border + head + apple)
    map_frame(0, "frame1");
    chk("frame1.dcount", 8'(dcount), 8'd54);
    // identical frame: no differences
    map_frame(0, "frame2");
    chk("frame2.dcount", 8'(dcount), 8'd0);
    // moved snake: changes at (4,4),(5,4),(6,4),(7,4)
    map_frame(1, "frame3");
    chk("frame3.dcount", 8'(dcount), 8'd4);

    // priority at current cell, no clocking
    set_in(4'b1111);
    chk("prio.all", 8'(obj_code), 8'd1);
    set_in(4'b0101);
    chk("prio.body_border", 8'(obj_code), 8'd2);
    set_in(4'b0011);
    chk("prio.apple_border", 8'(obj_code), 8'd3);
    set_in(4'b0001);
    chk("prio.border", 8'(obj_code), 8'd4);
    check_all("prio.model");

    // random traffic up to the last cell of the frame
    while (pos != 191) begin
      set_in(4'($urandom_range(0, 15)));
      check_all("rand_run");
      tick();
    end
    chk("wrap.pre_x", 8'(x), 8'd15);
    chk("wrap.pre_y", 8'(y), 8'd11);
    tick();
    chk("wrap.post_x", 8'(x), 8'd0);
    chk("wrap.post_y", 8'(y), 8'd0);

    // enable low: position and store hold, outputs follow inputs
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(4'($urandom_range(0, 15)));
      check_all("hold");
      tick();
    end
    enable = 1'b1;

    // random traffic to (7,5), then mid-frame reset
    while (pos != 87) begin
      set_in(4'($urandom_range(0, 15)));
      check_all("rand_mid");
      tick();
    end
    chk("mid.pre_x", 8'(x), 8'd7);
    chk("mid.pre_y", 8'(y), 8'd5);
    set_in(4'b0000);
    nrst = 1'b1;
    #1;
    model_reset();
    check_all("mid_rst");
    for (int i = 0; i < 4; i++) begin
      set_in(4'($urandom_range(0, 15)));
      check_all("mid_rst_in");
    end
    tick();
    nrst = 1'b0;
    set_in(4'b0000);

    // full frame of empty cells: cleared store gives no differences
    dcount = 0;
    for (int i = 0; i < 192; i++) begin
      check_all("post_rst");
      if (diff) dcount++;
      tick();
    end
    chk("post_rst.dcount", 8'(dcount), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
